// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern source and detectors.
// PATTERN is transmitted MSB first.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1011;

endpackage

// File: rtl/pattern_ref_model.sv
// Overlapping Mealy reference: history window, match flag and
// saturating match counter, fed by one (bit, valid) pair per clock.
module pattern_ref_model
  import seq_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_bit,
  input  logic             i_valid,
  output logic             o_match,
  output logic [CNT_W-1:0] o_count
);

  logic [PAT_W-2:0] r_hist;
  logic             r_match;
  logic [CNT_W-1:0] r_count;
  logic [PAT_W-1:0] w_window;

  assign w_window = {r_hist, i_bit};

  // History is never cleared on a hit, so matches may overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist  <= '0;
      r_match <= 1'b0;
      r_count <= '0;
    end else begin
      r_match <= i_valid && (w_window == PATTERN);
      if (i_valid) begin
        r_hist <= w_window[PAT_W-2:0];
      end
      if (r_match && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_match = r_match;
  assign o_count = r_count;

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-in, MSB-first serial-out stimulus source with a built-in
// expected-match model for downstream sequence detectors.
module serial_pattern_tx
  import seq_pkg::*;
#(
  parameter int               DATA_W  = 16,
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int               CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              exp_match,
  output logic [CNT_W-1:0]  match_count
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_nxt;
  logic              r_dout;
  logic              w_dout_nxt;
  logic              r_dout_valid;
  logic              w_dout_valid_nxt;
  logic              w_emit;
  logic              w_last;
  logic              w_xfer;

  assign w_emit     = (r_state == SHIFT);
  assign w_last     = (r_bit_cnt == LAST);
  assign load_ready = (r_state == IDLE) || (w_emit && w_last);
  assign w_xfer     = load_valid && load_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_nxt   = SHIFT;
          w_shreg_nxt   = load_data;
          w_bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        w_dout_nxt       = r_shreg[DATA_W-1];
        w_dout_valid_nxt = 1'b1;
        w_shreg_nxt      = r_shreg << 1;
        w_bit_cnt_nxt    = r_bit_cnt + BW'(1);
        // Last bit: chain straight into the next word when one is taken.
        if (w_last) begin
          w_bit_cnt_nxt = '0;
          if (w_xfer) begin
            w_shreg_nxt = load_data;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == SHIFT);

  pattern_ref_model #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .CNT_W  (CNT_W)
  ) u_ref (
    .clk    (clk),
    .reset  (reset),
    .i_bit  (r_shreg[DATA_W-1]),
    .i_valid(w_emit),
    .o_match(exp_match),
    .o_count(match_count)
  );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed and random words checked every
// cycle against a queue-based model of the serial stream.
module tb_serial_pattern_tx;

  localparam int         DW  = 16;
  localparam logic [3:0] PAT = 4'b1011;

  logic          clk;
  logic          reset;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          dout;
  logic          dout_valid;
  logic          busy;
  logic          exp_match;
  logic [7:0]    match_count;

  serial_pattern_tx dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .exp_match  (exp_match),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;

  logic pend[$];
  logic strm[$];
  int   nmatch = 0;
  logic e_dout, e_val, e_match;
  int   e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic m_ready();
    return pend.size() <= 1;
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic rst);
    logic       xfer;
    logic       b;
    logic [3:0] w;
    load_valid = v;
    load_data  = d;
    reset      = rst;
    #1;
    if (!rst) chk("load_ready", {31'd0, load_ready}, {31'd0, m_ready()});
    xfer = v && m_ready() && !rst;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      strm.delete();
      nmatch  = 0;
      e_cnt   = 0;
      e_dout  = 1'b0;
      e_val   = 1'b0;
      e_match = 1'b0;
    end else begin
      e_cnt   = (nmatch > 255) ? 255 : nmatch;
      e_dout  = 1'b0;
      e_val   = 1'b0;
      e_match = 1'b0;
      if (pend.size() > 0) begin
        b = pend.pop_front();
        strm.push_back(b);
        e_val  = 1'b1;
        e_dout = b;
        if (strm.size() >= 4) begin
          w = {strm[strm.size()-4], strm[strm.size()-3],
               strm[strm.size()-2], strm[strm.size()-1]};
          e_match = (w == PAT);
        end
        if (e_match) nmatch++;
      end
      if (xfer) begin
        for (int i = DW - 1; i >= 0; i--) pend.push_back(d[i]);
      end
    end
    @(negedge clk);
    chk("dout",        {31'd0, dout},        {31'd0, e_dout});
    chk("dout_valid",  {31'd0, dout_valid},  {31'd0, e_val});
    chk("exp_match",   {31'd0, exp_match},   {31'd0, e_match});
    chk("match_count", {24'd0, match_count}, e_cnt);
    chk("busy",        {31'd0, busy},        {31'd0, pend.size() > 0});
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic acc;
    for (int i = 0; i < 40; i++) begin
      acc = m_ready();
      step(1'b1, d, 1'b0);
      if (acc) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    @(negedge clk);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("reset_ready", {31'd0, load_ready}, 32'd1);
    idle(5);

    send(16'hB000);
    idle(18);
    chk("single_cnt", {24'd0, match_count}, 32'd1);

    send(16'hB6DA);
    idle(18);
    chk("overlap_cnt", {24'd0, match_count}, 32'd5);

    send(16'h0001);
    send(16'h6000);
    idle(18);
    chk("crossword_cnt", {24'd0, match_count}, 32'd6);

    send(16'hFFFF);
    idle(5);
    step(1'b0, '0, 1'b1);
    idle(2);
    send(16'h3000);
    idle(18);
    chk("midreset_cnt", {24'd0, match_count}, 32'd0);

    for (int i = 0; i < 70; i++) send(16'hB6DA);
    idle(18);
    chk("sat_cnt", {24'd0, match_count}, 32'd255);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom),
           $urandom_range(0, 149) == 0);
    end
    idle(18);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
